// File: rtl/vs_result_buffer_ctrl.sv
// Value-skip result buffer controller: hands out result slots, captures execute
// results and serves registered pickups from skipped instructions.
module vs_result_buffer_ctrl #(
    parameter  int unsigned RESULT_BUFFER_SIZE    = 8,
    localparam int unsigned RESULT_BUFFER_ID_SIZE = $clog2(RESULT_BUFFER_SIZE)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             alloc_req,
    output logic                             alloc_gnt,
    output logic [RESULT_BUFFER_ID_SIZE-1:0] alloc_idx,
    input  logic                             wr_en,
    input  logic [RESULT_BUFFER_ID_SIZE-1:0] wr_idx,
    input  logic [31:0]                      wr_data,
    input  logic                             pick_en,
    input  logic [RESULT_BUFFER_ID_SIZE-1:0] pick_idx,
    input  logic                             pick_release,
    output logic                             pick_valid,
    output logic [31:0]                      pick_data,
    input  logic                             flush,
    output logic [RESULT_BUFFER_ID_SIZE:0]   free_count,
    output logic                             full,
    output logic                             empty,
    output logic                             err
);

    localparam int unsigned N     = RESULT_BUFFER_SIZE;
    localparam int unsigned ID_W  = RESULT_BUFFER_ID_SIZE;
    localparam int unsigned CNT_W = RESULT_BUFFER_ID_SIZE + 1;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_VALID = 2'd2
    } ent_state_e;

    ent_state_e       ent_state     [N];
    ent_state_e       ent_state_nxt [N];
    logic [31:0]      ent_data      [N];
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_nxt;

    logic             srch_found;
    logic [ID_W-1:0]  srch_idx;
    logic             grant;
    logic             wr_ok;
    logic             wr_bad;
    logic             pick_hit;
    logic             pick_bad;

    // Entry state and round-robin pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                ent_state[ID_W'(i)] <= ST_FREE;
            end
            rr_ptr <= '0;
        end else begin
            ent_state <= ent_state_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

    // First FREE entry at or after rr_ptr, wrapping
    always_comb begin
        srch_found = 1'b0;
        srch_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!srch_found && ent_state[rr_ptr + ID_W'(k)] == ST_FREE) begin
                srch_found = 1'b1;
                srch_idx   = rr_ptr + ID_W'(k);
            end
        end
    end

    // Next-state: flush overrides; grant, write and release target disjoint states
    always_comb begin
        ent_state_nxt = ent_state;
        rr_ptr_nxt    = rr_ptr;
        grant    = alloc_req && srch_found && !flush;
        wr_ok    = wr_en && !flush && (ent_state[wr_idx] == ST_ALLOC);
        wr_bad   = wr_en && !flush && (ent_state[wr_idx] != ST_ALLOC);
        pick_hit = pick_en && !flush && (ent_state[pick_idx] == ST_VALID);
        pick_bad = pick_en && !flush && (ent_state[pick_idx] == ST_FREE);
        if (flush) begin
            for (int unsigned i = 0; i < N; i++) begin
                ent_state_nxt[ID_W'(i)] = ST_FREE;
            end
            rr_ptr_nxt = '0;
        end else begin
            if (grant) begin
                ent_state_nxt[srch_idx] = ST_ALLOC;
                rr_ptr_nxt              = srch_idx + ID_W'(1);
            end
            if (wr_ok) begin
                ent_state_nxt[wr_idx] = ST_VALID;
            end
            if (pick_hit && pick_release) begin
                ent_state_nxt[pick_idx] = ST_FREE;
            end
        end
    end

    // Result storage, registered pickup and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                ent_data[ID_W'(i)] <= '0;
            end
            pick_valid <= 1'b0;
            pick_data  <= '0;
            err        <= 1'b0;
        end else begin
            if (wr_ok) begin
                ent_data[wr_idx] <= wr_data;
            end
            pick_valid <= pick_hit;
            if (pick_hit) begin
                pick_data <= ent_data[pick_idx];
            end
            if (wr_bad || pick_bad) begin
                err <= 1'b1;
            end
        end
    end

    // Outputs; grant is masked while reset is asserted
    always_comb begin
        free_count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ent_state[ID_W'(i)] == ST_FREE) begin
                free_count = free_count + CNT_W'(1);
            end
        end
        alloc_gnt = grant && !reset;
        alloc_idx = srch_idx;
        full      = (free_count == '0);
        empty     = (free_count == CNT_W'(N));
    end

endmodule
